uart_mmio_controller: RTL and testbench

//  Memory-mapped front end that sequences the UART sender/receiver pair for the MIPS core.
//  - Buffers CPU TX bytes in a small FIFO and issues one start pulse per byte to the sender.
//  - Captures received bytes into a holding register with valid/overrun flags.
//  - Exposes control/status bits and a level interrupt on the data-memory peripheral bus.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_mmio_controller.sv | 192 +++++++++++++++++++
 tb/tb_uart_mmio_controller.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO front end: bus addresses,
// control/status bit positions and the TX sequencer state encoding.
package uart_pkg;

    // Word addresses on the data-memory peripheral bus (addr[1:0] ignored).
    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    // Control/status register bit positions.
    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_IDLE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_RX_OVR   = 4;
    localparam int CON_TX_DROP  = 5;

    // TX sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous show-ahead FIFO for outgoing UART bytes.
// Pointers carry an extra MSB so full and empty are distinguishable
// with exactly DEPTH usable entries. A push while full is accepted
// when a pop happens in the same cycle, since the pop frees the slot.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Head entry is presented directly so the sequencer can latch it on the pop cycle.
    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted pops/pushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_controller.sv
// Memory-mapped UART front end: TX byte FIFO feeding a start/wait/gap
// sequencer for the sender, an RX holding register with valid/overrun
// flags, a control/status register and a registered level interrupt.
module uart_mmio_controller
    import uart_pkg::*;
#(
    parameter int TX_DEPTH   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Registers
    logic [1:0]    r_state;
    logic [GW-1:0] r_gap_cnt;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_rx_hold;
    logic          r_rx_valid;
    logic          r_rx_ovr;
    logic          r_tx_drop;
    logic          r_tx_ie;
    logic          r_rx_ie;
    logic          r_irq;

    // Decode and datapath wires
    logic        w_txd_hit;
    logic        w_rxd_hit;
    logic        w_con_hit;
    logic        w_txd_wr;
    logic        w_rxd_rd;
    logic        w_con_wr;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_pop;
    logic [7:0]  w_fifo_dout;
    logic        w_tx_idle;
    logic        w_tx_drop_set;
    logic        w_rx_ovr_set;
    logic [31:0] w_con_value;
    logic        w_unused;

    assign w_txd_hit = (addr[31:2] == ADDR_TXD[31:2]);
    assign w_rxd_hit = (addr[31:2] == ADDR_RXD[31:2]);
    assign w_con_hit = (addr[31:2] == ADDR_CON[31:2]);

    assign w_txd_wr = wr_en && w_txd_hit;
    assign w_rxd_rd = rd_en && w_rxd_hit;
    assign w_con_wr = wr_en && w_con_hit;

    // Byte lane and sub-word address bits carry no meaning here.
    assign w_unused = &{1'b0, addr[1:0], wdata[31:8]};

    assign w_fifo_pop = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_tx_idle  = w_fifo_empty && (r_state == ST_IDLE);

    // A full FIFO drops the byte unless the sequencer frees a slot this cycle.
    assign w_tx_drop_set = w_txd_wr && w_fifo_full && !w_fifo_pop;
    // Overrun only when an unread byte is overwritten; a same-cycle RXD read consumes it.
    assign w_rx_ovr_set  = rx_done && r_rx_valid && !w_rxd_rd;

    assign w_con_value = {26'b0, r_tx_drop, r_rx_ovr, r_rx_valid, w_tx_idle, r_rx_ie, r_tx_ie};

    assign tx_data  = r_tx_data;
    assign tx_start = (r_state == ST_START);
    assign irq      = r_irq;

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_txd_wr),
        .pop   (w_fifo_pop),
        .din   (wdata[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // TX sequencer: latch head byte, pulse start, wait for done, then hold off GAP_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_tx_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fifo_pop) begin
                        r_tx_data <= w_fifo_dout;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RX holding register with valid and sticky overrun flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_hold  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (rx_done) begin
                r_rx_hold  <= rx_data;
                r_rx_valid <= 1'b1;
            end else if (w_rxd_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_ovr_set) begin
                r_rx_ovr <= 1'b1;
            end else if (w_con_wr && wdata[CON_RX_OVR]) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

    // Control bits and the sticky TX drop flag; a same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_ie   <= 1'b0;
            r_rx_ie   <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            if (w_con_wr) begin
                r_tx_ie <= wdata[CON_TX_IE];
                r_rx_ie <= wdata[CON_RX_IE];
            end
            if (w_tx_drop_set) begin
                r_tx_drop <= 1'b1;
            end else if (w_con_wr && wdata[CON_TX_DROP]) begin
                r_tx_drop <= 1'b0;
            end
        end
    end

    // Registered level interrupt, one cycle behind its cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_tx_ie && w_tx_idle) || (r_rx_ie && r_rx_valid);
        end
    end

    // Combinational read mux; TXD and unmapped addresses read as zero.
    always_comb begin
        rdata = 32'h0;
        if (w_rxd_hit) begin
            rdata = {24'h0, r_rx_hold};
        end else if (w_con_hit) begin
            rdata = w_con_value;
        end
    end

endmodule

// File: tb/tb_uart_mmio_controller.sv
// Bench for uart_mmio_controller: TX bytes go through a scoreboard queue
// checked on each tx_start, RX/CON behaviour runs from a vector table,
// and overflow and mid-frame reset are hand-written sequences.
module tb_uart_mmio_controller;
    import uart_pkg::*;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_done = 1'b0;

    uart_mmio_controller #(
        .TX_DEPTH   (4),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_done  (rx_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rx;
        logic [7:0]  rx_byte;
        logic [31:0] exp_rdata;
        bit          chk_irq;
        bit          exp_irq;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         auto_en = 1'b0;
    int         last_wr_cyc = 0;
    logic [7:0] sb[$];
    int         start_log[$];
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input string n, input bit wr, input bit rd, input logic [31:0] a,
                                input logic [31:0] wd, input bit rx, input logic [7:0] rb,
                                input logic [31:0] er, input bit ci, input bit ei);
        vec_t v;
        v.name = n; v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd;
        v.rx = rx; v.rx_byte = rb; v.exp_rdata = er; v.chk_irq = ci; v.exp_irq = ei;
        return v;
    endfunction

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Every start pulse must carry the oldest outstanding byte.
    task automatic tx_monitor();
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                start_log.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tx_start: got tx_data %h expected no start (cycle %0d)", tx_data, cyc);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    $display("tx start cycle %0d data %h expected %h", cyc, tx_data, exp_b);
                    check("tx_data", 32'(tx_data), 32'(exp_b));
                end
            end
        end
    endtask

    // Sender model: tx_done 10 cycles after each start while enabled.
    task automatic tx_responder();
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && auto_en) begin
                repeat (10) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    endtask

    task automatic watchdog();
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        last_wr_cyc = cyc;
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write %h <= %h", a, d);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        #1;
        d = rdata;
        @(negedge clk);
        rd_en = 1'b0;
        $display("read  %h => %h", a, d);
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && start_log.size() < target; i++) @(negedge clk);
        check("start_count", 32'(start_log.size()), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            addr = ADDR_CON;
            #1;
            if (rdata[CON_TX_IDLE]) ok = 1'b1;
        end
        check("tx_idle_reached", 32'(ok), 32'h1);
    endtask

    task automatic apply_vec(input vec_t v, input int k);
        logic [31:0] got;
        @(negedge clk);
        addr = v.addr; wr_en = v.wr; wdata = v.wdata; rd_en = v.rd;
        rx_done = v.rx; rx_data = v.rx_byte;
        #1;
        got = rdata;
        $display("vec %0d %s: addr=%h rdata=%h irq=%b", k, v.name, v.addr, got, irq);
        if (v.rd) check(v.name, got, v.exp_rdata);
        if (v.chk_irq) check({v.name, "_irq"}, 32'(irq), 32'(v.exp_irq));
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; rx_done = 1'b0;
    endtask

    initial begin
        int          n0;
        int          w0;
        logic [31:0] d;

        fork
            cycle_counter();
            tx_monitor();
            tx_responder();
            watchdog();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        addr = ADDR_CON;
        #1;
        check("reset_con", rdata, 32'h4);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_tx_data", 32'(tx_data), 32'h0);
        check("reset_tx_start", 32'(tx_start), 32'h0);
        addr = ADDR_TXD;
        #1;
        check("txd_reads_zero", rdata, 32'h0);
        addr = 32'h4000_0024;
        #1;
        check("unmapped_zero", rdata, 32'h0);
        repeat (10) @(negedge clk);
        check("no_start_after_reset", 32'(start_log.size()), 32'h0);

        // Two bytes through a responsive sender
        auto_en = 1'b1;
        n0 = start_log.size();
        sb.push_back(8'h41);
        cpu_write(ADDR_TXD, 32'h41);
        w0 = last_wr_cyc;
        sb.push_back(8'h42);
        cpu_write(ADDR_TXD, 32'h42);
        wait_starts(n0 + 2, 200);
        if (start_log.size() >= n0 + 2) begin
            check("start_latency", 32'(start_log[n0] - w0), 32'd2);
            check("start_gap_ok", 32'(start_log[n0+1] - start_log[n0] >= GAP + 1), 32'h1);
        end
        wait_idle(200);
        check("tx_queue_empty", 32'(sb.size()), 32'h0);

        // RX, overrun, same-cycle read, control and interrupt timing
        vecs.push_back(mk("rx_5a",       0, 0, ADDR_CON, 0,     1, 8'h5A, 0,     0, 0));
        vecs.push_back(mk("con_valid",   0, 1, ADDR_CON, 0,     0, 8'h00, 32'h0C, 0, 0));
        vecs.push_back(mk("rxd_5a",      0, 1, ADDR_RXD, 0,     0, 8'h00, 32'h5A, 0, 0));
        vecs.push_back(mk("con_cleared", 0, 1, ADDR_CON, 0,     0, 8'h00, 32'h04, 0, 0));
        vecs.push_back(mk("rx_11",       0, 0, ADDR_CON, 0,     1, 8'h11, 0,     0, 0));
        vecs.push_back(mk("rx_33",       0, 0, ADDR_CON, 0,     1, 8'h33, 0,     0, 0));
        vecs.push_back(mk("con_ovr",     0, 1, ADDR_CON, 0,     0, 8'h00, 32'h1C, 0, 0));
        vecs.push_back(mk("rxd_33",      0, 1, ADDR_RXD, 0,     0, 8'h00, 32'h33, 0, 0));
        vecs.push_back(mk("w1c_ovr",     1, 0, ADDR_CON, 32'h10, 0, 8'h00, 0,     0, 0));
        vecs.push_back(mk("con_ovr_clr", 0, 1, ADDR_CON, 0,     0, 8'h00, 32'h04, 0, 0));
        vecs.push_back(mk("rx_66",       0, 0, ADDR_CON, 0,     1, 8'h66, 0,     0, 0));
        vecs.push_back(mk("rxd_rx_77",   0, 1, ADDR_RXD, 0,     1, 8'h77, 32'h66, 0, 0));
        vecs.push_back(mk("con_no_ovr",  0, 1, ADDR_CON, 0,     0, 8'h00, 32'h0C, 0, 0));
        vecs.push_back(mk("rxd_77",      0, 1, ADDR_RXD, 0,     0, 8'h00, 32'h77, 0, 0));
        vecs.push_back(mk("con_empty",   0, 1, ADDR_CON, 0,     0, 8'h00, 32'h04, 0, 0));
        vecs.push_back(mk("set_ie",      1, 0, ADDR_CON, 32'h3, 0, 8'h00, 0,     0, 0));
        vecs.push_back(mk("con_ie",      0, 1, ADDR_CON, 0,     0, 8'h00, 32'h07, 1, 0));
        vecs.push_back(mk("irq_tx",      0, 1, ADDR_CON, 0,     0, 8'h00, 32'h07, 1, 1));
        vecs.push_back(mk("rx_ie_only",  1, 0, ADDR_CON, 32'h2, 0, 8'h00, 0,     0, 0));
        vecs.push_back(mk("rx_99",       0, 0, ADDR_CON, 0,     1, 8'h99, 0,     0, 0));
        vecs.push_back(mk("con_rx_ie",   0, 1, ADDR_CON, 0,     0, 8'h00, 32'h0E, 1, 0));
        vecs.push_back(mk("rxd_99",      0, 1, ADDR_RXD, 0,     0, 8'h00, 32'h99, 1, 1));
        vecs.push_back(mk("con_irq_lag", 0, 1, ADDR_CON, 0,     0, 8'h00, 32'h06, 1, 1));
        vecs.push_back(mk("con_irq_off", 0, 1, ADDR_CON, 0,     0, 8'h00, 32'h06, 1, 0));
        vecs.push_back(mk("ie_off",      1, 0, ADDR_CON, 32'h0, 0, 8'h00, 0,     0, 0));
        for (int k = 0; k < vecs.size(); k++) apply_vec(vecs[k], k);

        // Six back-to-back writes into a stalled sender: 1 in flight + 4 queued, 1 dropped
        auto_en = 1'b0;
        n0 = start_log.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            addr = ADDR_TXD; wdata = 32'hA0 + 32'(i); wr_en = 1'b1;
            if (i < 5) sb.push_back(8'hA0 + 8'(i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("first_in_flight", 32'(start_log.size()), 32'(n0 + 1));
        cpu_read(ADDR_CON, d);
        check("con_tx_drop_set", d, 32'h20);
        cpu_write(ADDR_CON, 32'h20);
        cpu_read(ADDR_CON, d);
        check("con_tx_drop_cleared", d, 32'h00);
        @(negedge clk);
        tx_done = 1'b1;
        auto_en = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_starts(n0 + 5, 400);
        wait_idle(200);
        check("tx_queue_drained", 32'(sb.size()), 32'h0);
        repeat (20) @(negedge clk);
        check("no_extra_start", 32'(start_log.size()), 32'(n0 + 5));

        // Reset mid-WAIT with a byte in flight and one queued
        auto_en = 1'b0;
        n0 = start_log.size();
        cpu_write(ADDR_CON, 32'h3);
        sb.push_back(8'hC3);
        cpu_write(ADDR_TXD, 32'hC3);
        sb.push_back(8'hC4);
        cpu_write(ADDR_TXD, 32'hC4);
        wait_starts(n0 + 1, 50);
        repeat (3) @(negedge clk);
        cpu_read(ADDR_CON, d);
        check("con_busy_ie", d, 32'h03);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        addr = ADDR_CON;
        #1;
        check("rst_con", rdata, 32'h4);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_start", 32'(start_log.size()), 32'(n0 + 1));
        addr = ADDR_CON;
        #1;
        check("rst_con_after_done", rdata, 32'h4);
        check("rst_irq_after_done", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
